// File: rtl/mem_access_pkg.sv
// mem_access_pkg: widths, op/state encodings and size helpers for the MEM stage.
// MEM_LAST_WORD_CACHE_EN is left undefined by default (byte-serial path for every load).
package mem_access_pkg;
  localparam int RegLen = 32;
  localparam int RegAddrLen = 5;
  localparam int AddrLen = 32;
  localparam int ALU_Len = 5;
  localparam int InstLen = 32;
  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, DONE = 2'd2} state_e;
  localparam logic [ALU_Len-1:0] OP_NOP = 5'd0;
  localparam logic [ALU_Len-1:0] OP_ADD = 5'd1;
  localparam logic [ALU_Len-1:0] OP_LB = 5'd16;
  localparam logic [ALU_Len-1:0] OP_LH = 5'd17;
  localparam logic [ALU_Len-1:0] OP_LW = 5'd18;
  localparam logic [ALU_Len-1:0] OP_LBU = 5'd19;
  localparam logic [ALU_Len-1:0] OP_LHU = 5'd20;
  localparam logic [ALU_Len-1:0] OP_SB = 5'd21;
  localparam logic [ALU_Len-1:0] OP_SH = 5'd22;
  localparam logic [ALU_Len-1:0] OP_SW = 5'd23;
  localparam logic [1:0] LAST_B = 2'd0;
  localparam logic [1:0] LAST_H = 2'd1;
  localparam logic [1:0] LAST_W = 2'd3;
  function automatic logic is_load(input logic [ALU_Len-1:0] op);
    return op inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};
  endfunction
  function automatic logic is_store(input logic [ALU_Len-1:0] op);
    return op inside {OP_SB, OP_SH, OP_SW};
  endfunction
  function automatic logic [1:0] last_idx(input logic [ALU_Len-1:0] op);
    return (op inside {OP_LB, OP_LBU, OP_SB}) ? LAST_B :
           (op inside {OP_LH, OP_LHU, OP_SH}) ? LAST_H : LAST_W;
  endfunction
endpackage

// File: rtl/mem_access_load_extend.sv
// load_extend: sign/zero extension of the assembled load word for write-back.
module load_extend
  import mem_access_pkg::*;
(
  input  logic [ALU_Len-1:0] i_op,
  input  logic [31:0]        i_buf,
  output logic [RegLen-1:0]  o_data
);
  always_comb
    o_data = (i_op == OP_LB)  ? {{24{i_buf[7]}}, i_buf[7:0]} :
             (i_op == OP_LH)  ? {{16{i_buf[15]}}, i_buf[15:0]} :
             (i_op == OP_LBU) ? {24'd0, i_buf[7:0]} :
             (i_op == OP_LHU) ? {16'd0, i_buf[15:0]} : i_buf;
endmodule

// File: rtl/mem_access.sv
// mem_access: MEM stage with byte-serial load/store against the memory controller.
// Optional one-entry last-word load cache when MEM_LAST_WORD_CACHE_EN is defined.
module mem_access
  import mem_access_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [RegLen-1:0]     rd_data_i,
  input  logic [RegAddrLen-1:0] rd_addr_i,
  input  logic                  rd_enable_i,
  input  logic [AddrLen-1:0]    mem_addr_i,
  input  logic [ALU_Len-1:0]    alu_op_i,
  input  logic [InstLen-1:0]    mem_wdata_i,
  output logic [RegLen-1:0]     wb_rd_data_o,
  output logic [RegAddrLen-1:0] wb_rd_addr_o,
  output logic                  wb_rd_enable_o,
  output logic                  stall_req_o,
  output logic                  ctrl_req_o,
  output logic                  ctrl_we_o,
  output logic [AddrLen-1:0]    ctrl_addr_o,
  output logic [7:0]            ctrl_wdata_o,
  input  logic                  ctrl_ready_i,
  input  logic [7:0]            ctrl_rdata_i
);
  state_e r_state, w_next;
  logic [1:0] r_cnt;
  logic [ALU_Len-1:0] r_op;
  logic [AddrLen-1:0] r_addr;
  logic [31:0] r_wdata, r_buf;
  logic [RegLen-1:0] w_ext, w_hit_data;
  logic w_mem, w_hit, w_store, w_start;
  logic [1:0] w_last;
  assign w_mem = is_load(alu_op_i) | is_store(alu_op_i);
  assign w_store = is_store(r_op);
  assign w_last = last_idx(r_op);
  assign w_start = (r_state == IDLE) && w_mem && !w_hit;
  load_extend u_ext (.i_op(r_op), .i_buf(r_buf), .o_data(w_ext));
`ifdef MEM_LAST_WORD_CACHE_EN
  logic r_cv;
  logic [AddrLen-3:0] r_ctag;
  logic [31:0] r_cdata;
  logic w_touch;
  logic [AddrLen-1:0] w_baddr;
  assign w_hit = r_cv && alu_op_i == OP_LW && mem_addr_i[1:0] == 2'd0 && mem_addr_i[AddrLen-1:2] == r_ctag;
  assign w_hit_data = r_cdata;
  // a store may straddle two words, so every byte it writes is checked
  always_comb begin
    w_touch = 1'b0;
    w_baddr = '0;
    for (int k = 0; k < 4; k++) begin
      w_baddr = mem_addr_i + AddrLen'(k);
      if (2'(k) <= last_idx(alu_op_i) && w_baddr[AddrLen-1:2] == r_ctag) w_touch = 1'b1;
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_cv <= 1'b0;
      r_ctag <= '0;
      r_cdata <= '0;
    end else if (r_state == DONE && r_op == OP_LW && r_addr[1:0] == 2'd0) begin
      r_cv <= 1'b1;
      r_ctag <= r_addr[AddrLen-1:2];
      r_cdata <= r_buf;
    end else if (r_state == IDLE && is_store(alu_op_i) && w_touch)
      r_cv <= 1'b0;
`else
  assign w_hit = 1'b0;
  assign w_hit_data = '0;
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state <= IDLE;
      r_cnt <= '0;
      r_op <= OP_NOP;
      r_addr <= '0;
      r_wdata <= '0;
      r_buf <= '0;
    end else begin
      r_state <= w_next;
      if (w_start) begin
        r_cnt <= '0;
        r_op <= alu_op_i;
        r_addr <= mem_addr_i;
        r_wdata <= mem_wdata_i;
        r_buf <= '0;
      end else if (r_state == ACCESS && ctrl_ready_i) begin
        if (!w_store) r_buf[8*r_cnt +: 8] <= ctrl_rdata_i;
        if (r_cnt != w_last) r_cnt <= r_cnt + 2'd1;
      end
    end
  always_comb begin
    w_next = IDLE;
    wb_rd_data_o = rd_data_i;
    wb_rd_addr_o = rd_addr_i;
    wb_rd_enable_o = rd_enable_i;
    stall_req_o = 1'b0;
    ctrl_req_o = 1'b0;
    ctrl_we_o = 1'b0;
    ctrl_addr_o = '0;
    ctrl_wdata_o = '0;
    case (r_state)
      IDLE: begin
        w_next = w_start ? ACCESS : IDLE;
        stall_req_o = w_start;
        wb_rd_data_o = w_hit ? w_hit_data : rd_data_i;
      end
      ACCESS: begin
        w_next = (ctrl_ready_i && r_cnt == w_last) ? DONE : ACCESS;
        stall_req_o = 1'b1;
        ctrl_req_o = 1'b1;
        ctrl_we_o = w_store;
        ctrl_addr_o = r_addr + AddrLen'(r_cnt);
        ctrl_wdata_o = r_wdata[8*r_cnt +: 8];
      end
      DONE: begin
        wb_rd_data_o = w_store ? '0 : w_ext;
        wb_rd_enable_o = w_store ? 1'b0 : rd_enable_i;
      end
      default: w_next = IDLE;
    endcase
    // outputs are forced low for the whole time reset is held
    if (rst) begin
      wb_rd_data_o = '0;
      wb_rd_addr_o = '0;
      wb_rd_enable_o = 1'b0;
      stall_req_o = 1'b0;
      ctrl_req_o = 1'b0;
      ctrl_we_o = 1'b0;
      ctrl_addr_o = '0;
      ctrl_wdata_o = '0;
    end
  end
endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: directed bench for mem_access with a scoreboard of byte transfers and results.
module tb_mem_access;
  import mem_access_pkg::*;
  typedef struct packed {
    logic we;
    logic [31:0] addr;
    logic [7:0] wdata;
  } xfer_t;
  typedef struct packed {
    logic [31:0] data;
    logic en;
  } res_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [31:0] rd_data_i = 32'hCAFE_F00D;
  logic [4:0] rd_addr_i = 5'd9;
  logic rd_enable_i = 1'b1;
  logic [31:0] mem_addr_i = 32'h0;
  logic [4:0] alu_op_i = OP_NOP;
  logic [31:0] mem_wdata_i = 32'h0;
  logic [31:0] wb_rd_data_o;
  logic [4:0] wb_rd_addr_o;
  logic wb_rd_enable_o, stall_req_o, ctrl_req_o, ctrl_we_o;
  logic [31:0] ctrl_addr_o;
  logic [7:0] ctrl_wdata_o;
  logic ctrl_ready_i = 1'b0;
  logic [7:0] ctrl_rdata_i = 8'h0;
  int errors = 0;
  int checks = 0;
  xfer_t q_x[$];
  res_t q_r[$];
  always #5 clk = ~clk;
  mem_access dut (
    .clk(clk), .rst(rst), .rd_data_i(rd_data_i), .rd_addr_i(rd_addr_i), .rd_enable_i(rd_enable_i),
    .mem_addr_i(mem_addr_i), .alu_op_i(alu_op_i), .mem_wdata_i(mem_wdata_i),
    .wb_rd_data_o(wb_rd_data_o), .wb_rd_addr_o(wb_rd_addr_o), .wb_rd_enable_o(wb_rd_enable_o),
    .stall_req_o(stall_req_o), .ctrl_req_o(ctrl_req_o), .ctrl_we_o(ctrl_we_o),
    .ctrl_addr_o(ctrl_addr_o), .ctrl_wdata_o(ctrl_wdata_o),
    .ctrl_ready_i(ctrl_ready_i), .ctrl_rdata_i(ctrl_rdata_i)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  // one load/store; rbytes supplies read bytes little-endian, waits stalls byte 0
  task automatic mem_op(input string tag, input logic [4:0] op, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] rbytes, input int n,
                        input int waits, input logic [31:0] exp_data);
    logic st;
    xfer_t x;
    res_t r;
    int stalls, k, w;
    bit done;
    st = (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    for (int i = 0; i < n; i++) begin
      x.we = st;
      x.addr = addr + i;
      x.wdata = wdata[8*i +: 8];
      q_x.push_back(x);
    end
    r.data = st ? 32'h0 : exp_data;
    r.en = !st;
    q_r.push_back(r);
    alu_op_i = op;
    mem_addr_i = addr;
    mem_wdata_i = wdata;
    rd_addr_i = 5'd7;
    rd_enable_i = 1'b1;
    rd_data_i = 32'hDEAD_BEEF;
    stalls = 0;
    k = 0;
    w = waits;
    done = 0;
    for (int c = 0; c < 60 && !done; c++) begin
      @(negedge clk);
      if (stall_req_o) stalls++;
      if (ctrl_req_o) begin
        if (q_x.size() == 0) begin
          checks++;
          errors++;
          $error("FAIL %s.extra_req: observed request at %h, expected none", tag, ctrl_addr_o);
          ctrl_ready_i = 1'b1;
        end else begin
          x = q_x[0];
          chk({tag, ".ctrl_addr"}, ctrl_addr_o, x.addr);
          chk({tag, ".ctrl_we"}, {31'd0, ctrl_we_o}, {31'd0, x.we});
          if (x.we) chk({tag, ".ctrl_wdata"}, {24'd0, ctrl_wdata_o}, {24'd0, x.wdata});
          if (w > 0) begin
            w--;
            ctrl_ready_i = 1'b0;
          end else begin
            ctrl_ready_i = 1'b1;
            ctrl_rdata_i = rbytes[8*k +: 8];
            void'(q_x.pop_front());
            k++;
          end
        end
      end else if (stalls > 0 && !stall_req_o) begin
        done = 1;
        r = q_r.pop_front();
        chk({tag, ".wb_data"}, wb_rd_data_o, r.data);
        chk({tag, ".wb_en"}, {31'd0, wb_rd_enable_o}, {31'd0, r.en});
        chk({tag, ".wb_addr"}, {27'd0, wb_rd_addr_o}, 32'd7);
        chk({tag, ".stall_cycles"}, stalls, n + 1 + waits);
      end
      @(posedge clk);
      #1 ctrl_ready_i = 1'b0;
    end
    if (!done) begin
      checks++;
      errors++;
      $error("FAIL %s.timeout: observed no DONE cycle, expected one within 60 cycles", tag);
      q_x.delete();
      q_r.delete();
    end
    alu_op_i = OP_NOP;
  endtask
  initial begin
    #2;
    chk("rst.wb_data", wb_rd_data_o, 32'h0);
    chk("rst.wb_addr", {27'd0, wb_rd_addr_o}, 32'h0);
    chk("rst.wb_en", {31'd0, wb_rd_enable_o}, 32'h0);
    chk("rst.stall", {31'd0, stall_req_o}, 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    alu_op_i = OP_ADD;
    rd_data_i = 32'h1234_5678;
    rd_addr_i = 5'd5;
    rd_enable_i = 1'b1;
    #1;
    chk("add.wb_data", wb_rd_data_o, 32'h1234_5678);
    chk("add.wb_addr", {27'd0, wb_rd_addr_o}, 32'd5);
    chk("add.wb_en", {31'd0, wb_rd_enable_o}, 32'd1);
    chk("add.stall", {31'd0, stall_req_o}, 32'd0);
    chk("add.ctrl_req", {31'd0, ctrl_req_o}, 32'd0);
    @(posedge clk);
    #1;
    mem_op("lw", OP_LW, 32'h100, 32'h0, 32'h1234_5678, 4, 0, 32'h1234_5678);
    mem_op("lb", OP_LB, 32'h203, 32'h0, 32'h0000_0080, 1, 0, 32'hFFFF_FF80);
    mem_op("lbu", OP_LBU, 32'h203, 32'h0, 32'h0000_0080, 1, 0, 32'h0000_0080);
    mem_op("lh", OP_LH, 32'h201, 32'h0, 32'h0000_FFFE, 2, 0, 32'hFFFF_FFFE);
    mem_op("lhu", OP_LHU, 32'h201, 32'h0, 32'h0000_FFFE, 2, 1, 32'h0000_FFFE);
    mem_op("sh", OP_SH, 32'h301, 32'hAABB_CCDD, 32'h0, 2, 2, 32'h0);
    mem_op("sw_wrap", OP_SW, 32'hFFFF_FFFE, 32'h0102_0304, 32'h0, 4, 0, 32'h0);
    mem_op("lw_mis", OP_LW, 32'h0000_0105, 32'h0, 32'h8899_AABB, 4, 3, 32'h8899_AABB);
    // abort a LW after two bytes have been accepted
    alu_op_i = OP_LW;
    mem_addr_i = 32'h500;
    @(negedge clk);
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      ctrl_ready_i = 1'b1;
      ctrl_rdata_i = 8'h11;
      @(posedge clk);
      #1 ctrl_ready_i = 1'b0;
    end
    @(negedge clk);
    chk("abort.pre_addr", ctrl_addr_o, 32'h502);
    rst = 1'b1;
    #1;
    chk("abort.ctrl_req", {31'd0, ctrl_req_o}, 32'd0);
    chk("abort.stall", {31'd0, stall_req_o}, 32'd0);
    chk("abort.ctrl_addr", ctrl_addr_o, 32'h0);
    chk("abort.wb_data", wb_rd_data_o, 32'h0);
    chk("abort.wb_en", {31'd0, wb_rd_enable_o}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    alu_op_i = OP_ADD;
    rd_data_i = 32'h0BAD_F00D;
    #1;
    chk("post_rst.wb_data", wb_rd_data_o, 32'h0BAD_F00D);
    chk("post_rst.stall", {31'd0, stall_req_o}, 32'd0);
    chk("post_rst.ctrl_req", {31'd0, ctrl_req_o}, 32'd0);
    @(posedge clk);
    #1;
    mem_op("lb_after_rst", OP_LB, 32'h600, 32'h0, 32'h0000_0042, 1, 0, 32'h0000_0042);
    mem_op("c_lw1", OP_LW, 32'h400, 32'h0, 32'hCAFE_BABE, 4, 0, 32'hCAFE_BABE);
`ifdef MEM_LAST_WORD_CACHE_EN
    alu_op_i = OP_LW;
    mem_addr_i = 32'h400;
    rd_data_i = 32'h0;
    @(negedge clk);
    chk("c_hit.stall", {31'd0, stall_req_o}, 32'd0);
    chk("c_hit.ctrl_req", {31'd0, ctrl_req_o}, 32'd0);
    chk("c_hit.wb_data", wb_rd_data_o, 32'hCAFE_BABE);
    @(posedge clk);
    #1 alu_op_i = OP_NOP;
    mem_op("c_sb", OP_SB, 32'h402, 32'h0000_0077, 32'h0, 1, 0, 32'h0);
    mem_op("c_lw_miss", OP_LW, 32'h400, 32'h0, 32'hCAFE_77BE, 4, 0, 32'hCAFE_77BE);
`else
    mem_op("c_lw2", OP_LW, 32'h400, 32'h0, 32'h1357_9BDF, 4, 0, 32'h1357_9BDF);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mem_access.md
# mem_access

Pipeline MEM stage of the RISC-V core, directly downstream of the EX/MEM pipeline register and upstream of MEM/WB. It passes ALU results through unchanged. For loads and stores it runs a byte-serial access against the memory controller, holding the pipeline with a stall request until the access completes. Load results are sign- or zero-extended before being handed to write-back.

## Interface
Parameters:
- None. Widths `RegLen`, `RegAddrLen`, `AddrLen`, `ALU_Len`, `InstLen` come from config.vh.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous, active-high.
- rd_data_i  in  `RegLen`  ALU result / passthrough value.
- rd_addr_i  in  `RegAddrLen`  destination register.
- rd_enable_i  in  1  destination write enable.
- mem_addr_i  in  `AddrLen`  effective byte address.
- alu_op_i  in  `ALU_Len`  operation code (LB/LH/LW/LBU/LHU/SB/SH/SW or other).
- mem_wdata_i  in  `InstLen`  store data.
- wb_rd_data_o  out  `RegLen`  result to MEM/WB.
- wb_rd_addr_o  out  `RegAddrLen`  destination to MEM/WB.
- wb_rd_enable_o  out  1  write enable to MEM/WB.
- stall_req_o  out  1  MEM-stage stall request to the stall controller.
- ctrl_req_o  out  1  byte request to the memory controller.
- ctrl_we_o  out  1  1 = write byte, 0 = read byte.
- ctrl_addr_o  out  `AddrLen`  byte address.
- ctrl_wdata_o  out  8  write byte.
- ctrl_ready_i  in  1  current byte accepted/completed this cycle.
- ctrl_rdata_i  in  8  read byte, valid when ctrl_ready_i = 1.

## Operation
- FSM states: IDLE, ACCESS, DONE. Encodings are defined in config.vh.
- **Non-memory op in IDLE:**
  - wb_* outputs equal the inputs combinationally.
  - stall_req_o = 0; ctrl_req_o = 0.
- **Memory op in IDLE:**
  - stall_req_o = 1 combinationally.
  - Next edge: go to ACCESS; byte counter `cnt` = 0; latch op, address and store data.
- **Access size:** B = 1 byte, H = 2 bytes, W = 4 bytes. Last byte index `last` = size−1.
- **ACCESS:**
  - Drive ctrl_req_o = 1, ctrl_addr_o = addr + cnt, ctrl_we_o = is_store, ctrl_wdata_o = wdata[8·cnt +: 8].
  - stall_req_o = 1.
  - Each edge with ctrl_ready_i = 1:
    - A read stores ctrl_rdata_i into buf[8·cnt +: 8].
    - If cnt == last, go to DONE; otherwise cnt increments.
  - Byte order is little-endian. Misaligned addresses are legal; no alignment check.
  - Address arithmetic wraps modulo 2^`AddrLen`.
- **DONE (exactly one cycle):**
  - stall_req_o = 0; ctrl_req_o = 0.
  - Load: wb_rd_data_o = extended buf (LB/LH sign-extend bit 7/15; LBU/LHU zero-extend; LW full word). wb_rd_addr_o and wb_rd_enable_o pass through.
  - Store: wb_rd_enable_o = 0, wb_rd_data_o = 0.
  - Next edge: go to IDLE. EX/MEM advances on that same edge.
- **Bytes not yet read:** buf is cleared when ACCESS is entered, so these bytes read as 0.
- **Reset (asynchronous, including mid-ACCESS):**
  - FSM goes to IDLE, cnt = 0, buf = 0.
  - All outputs read 0 while rst = 1.
  - The in-flight request is dropped; the memory controller discards a partially issued transfer.

## Timing
- Non-memory op: 0-cycle latency, no stall.
- Load/store of N bytes with zero-wait controller: stall_req_o high for N+1 cycles (IDLE detect + N ACCESS cycles), then 1 DONE cycle. Each wait cycle of ctrl_ready_i adds one cycle.
- ctrl_addr_o, ctrl_we_o and ctrl_wdata_o are stable while ctrl_req_o = 1 and ctrl_ready_i = 0.
- ctrl_req_o stays high across consecutive bytes; there is no idle gap between bytes.
- ctrl_ready_i is ignored outside ACCESS.

## Configuration
- Macro: `MEM_LAST_WORD_CACHE_EN`.
- **Defined:**
  - One-entry register {valid, word address, data} filled on completion of any LW with addr[1:0] = 0.
  - An LW in IDLE hitting a valid entry at the same address returns the cached data combinationally, with no stall and no ctrl request.
  - Any store whose byte range touches the cached word clears valid.
  - Reset clears valid.
- **Undefined:** every load takes the byte-serial path. No cache register exists.

## Structure
- config.vh holds:
  - load/store op encodings;
  - FSM state encodings;
  - size/last-index constants;
  - the `MEM_LAST_WORD_CACHE_EN` default.
- One sub-module, `load_extend`:
  - combinational;
  - inputs: op, 32-bit buf;
  - output: extended `RegLen` result.

## Test plan
- ADD passthrough with rd_data_i = 0x1234_5678, rd_addr_i = 5 → same values on wb_* in the same cycle; stall_req_o = 0; ctrl_req_o = 0.
- LW at 0x100, zero-wait, bytes 0x78, 0x56, 0x34, 0x12 → stall_req_o high for 5 cycles; ctrl_addr_o = 0x100..0x103; DONE shows 0x1234_5678.
- LB at 0x203, byte 0x80 → 0xFFFF_FF80. LBU at 0x203 → 0x0000_0080. LH at 0x201, bytes 0xFE, 0xFF → 0xFFFF_FFFE.
- SH at 0x301 with wdata 0xAABB_CCDD, ctrl_ready_i low 2 cycles on byte 0 → writes 0xDD @0x301 then 0xCC @0x302; wdata/addr stable during the wait; DONE has wb_rd_enable_o = 0.
- Reset asserted mid-LW at cnt = 2 → ctrl_req_o and stall_req_o drop immediately; state IDLE; all outputs 0.
- With `MEM_LAST_WORD_CACHE_EN` defined:
  - LW 0x400 followed by LW 0x400 → second returns with no stall and no ctrl request.
  - An intervening SB 0x402 → the following LW 0x400 takes the full byte-serial access.
